// File: rtl/reflet_vga_txt_writer.sv
`default_nettype none
// ============================================================================
// Module   : reflet_vga_txt_writer
// Purpose  : Terminal-style front end for the VGA text-mode renderer. It takes
//            a byte stream over a valid/ready handshake, keeps a cursor,
//            interprets LF/CR/BS/FF control codes and turns printable bytes
//            into single-cell writes on the renderer's text-memory port.
//            FF (0x0C) clears the whole screen with spaces, one cell per cycle.
// Ports    : clk, reset (async, active-low)
//            char_valid/char_in/char_ready : byte input handshake
//            *_fg_in/*_bg_in               : colours sampled on accept
//            write_en, h_txt_out, v_txt_out, char_out, *_fg_out, *_bg_out :
//                                            registered text-memory write
//            cursor_h/cursor_v             : current cursor cell
//            busy                          : high while clearing
// Option   : REFLET_TXT_WRITER_ESC_COLOR_EN -- 0x1B followed by a palette byte
//            selects 3-bit fg/bg colours; colour inputs are then ignored.
// Revision : 1.0 - initial release
// ============================================================================
module reflet_vga_txt_writer #(
  parameter int h_size        = 640,
  parameter int v_size        = 480,
  parameter int color_depth   = 8,
  parameter int bit_reduction = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      char_valid,
  input  logic [7:0]                                char_in,
  output logic                                      char_ready,
  input  logic [color_depth-1:0]                    R_fg_in,
  input  logic [color_depth-1:0]                    G_fg_in,
  input  logic [color_depth-1:0]                    B_fg_in,
  input  logic [color_depth-1:0]                    R_bg_in,
  input  logic [color_depth-1:0]                    G_bg_in,
  input  logic [color_depth-1:0]                    B_bg_in,
  output logic                                      write_en,
  output logic [$clog2(h_size/8)-bit_reduction-1:0] h_txt_out,
  output logic [$clog2(v_size/8)-bit_reduction-1:0] v_txt_out,
  output logic [7:0]                                char_out,
  output logic [color_depth-1:0]                    R_fg_out,
  output logic [color_depth-1:0]                    G_fg_out,
  output logic [color_depth-1:0]                    B_fg_out,
  output logic [color_depth-1:0]                    R_bg_out,
  output logic [color_depth-1:0]                    G_bg_out,
  output logic [color_depth-1:0]                    B_bg_out,
  output logic [$clog2(h_size/8)-bit_reduction-1:0] cursor_h,
  output logic [$clog2(v_size/8)-bit_reduction-1:0] cursor_v,
  output logic                                      busy
);

  localparam int HW   = $clog2(h_size/8) - bit_reduction;
  localparam int VW   = $clog2(v_size/8) - bit_reduction;
  localparam int COLS = (h_size/8) >> bit_reduction;
  localparam int ROWS = (v_size/8) >> bit_reduction;

  localparam logic [HW-1:0] LAST_COL = HW'(COLS-1);
  localparam logic [VW-1:0] LAST_ROW = VW'(ROWS-1);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
  localparam logic [7:0] CH_ESC   = 8'h1B;
`endif

`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ESC   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1
  } state_t;
`endif

  state_t state_q;
  state_t state_d;

  logic          ready_state;
  logic          accept;
  logic [HW-1:0] clr_h;
  logic [VW-1:0] clr_v;
  logic          clear_last;
  logic [VW-1:0] row_inc;
  logic [HW-1:0] adv_h;
  logic [VW-1:0] adv_v;
  logic [HW-1:0] clr_adv_h;
  logic [VW-1:0] clr_adv_v;

  logic [color_depth-1:0] sel_R_fg;
  logic [color_depth-1:0] sel_G_fg;
  logic [color_depth-1:0] sel_B_fg;
  logic [color_depth-1:0] sel_R_bg;
  logic [color_depth-1:0] sel_G_bg;
  logic [color_depth-1:0] sel_B_bg;

  // --------------------------------------------------------------------------
  // Handshake: ready depends only on state, but is forced low while reset is
  // held so nothing is accepted before the writer is out of reset.
  // --------------------------------------------------------------------------
  always_comb begin
    ready_state = (state_q == ST_IDLE);
`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
    if (state_q == ST_ESC) ready_state = 1'b1;
`endif
  end

  assign char_ready = reset & ready_state;
  assign accept     = char_valid & char_ready;
  assign busy       = (state_q == ST_CLEAR);

  // --------------------------------------------------------------------------
  // Cursor and clear-scan arithmetic (wrap on the last column/row, no scroll)
  // --------------------------------------------------------------------------
  assign row_inc    = (cursor_v == LAST_ROW) ? '0 : cursor_v + VW'(1);
  assign adv_h      = (cursor_h == LAST_COL) ? '0 : cursor_h + HW'(1);
  assign adv_v      = (cursor_h == LAST_COL) ? row_inc : cursor_v;

  assign clear_last = (clr_h == LAST_COL) && (clr_v == LAST_ROW);
  assign clr_adv_h  = (clr_h == LAST_COL) ? '0 : clr_h + HW'(1);
  assign clr_adv_v  = (clr_h == LAST_COL) ? clr_v + VW'(1) : clr_v;

  // --------------------------------------------------------------------------
  // Colour source: either the palette or the live colour inputs
  // --------------------------------------------------------------------------
`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
  logic [2:0] pal_fg;  // {B,G,R}
  logic [2:0] pal_bg;  // {B,G,R}
  logic       unused_colour_in;

  assign sel_R_fg = {color_depth{pal_fg[0]}};
  assign sel_G_fg = {color_depth{pal_fg[1]}};
  assign sel_B_fg = {color_depth{pal_fg[2]}};
  assign sel_R_bg = {color_depth{pal_bg[0]}};
  assign sel_G_bg = {color_depth{pal_bg[1]}};
  assign sel_B_bg = {color_depth{pal_bg[2]}};

  // Colour inputs are deliberately ignored when the palette is in use.
  assign unused_colour_in = ^{R_fg_in, G_fg_in, B_fg_in, R_bg_in, G_bg_in, B_bg_in};
`else
  assign sel_R_fg = R_fg_in;
  assign sel_G_fg = G_fg_in;
  assign sel_B_fg = B_fg_in;
  assign sel_R_bg = R_bg_in;
  assign sel_G_bg = G_bg_in;
  assign sel_B_bg = B_bg_in;
`endif

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (char_in == CH_FF) state_d = ST_CLEAR;
`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
          else if (char_in == CH_ESC) state_d = ST_ESC;
`endif
        end
      end
      ST_CLEAR: begin
        if (clear_last) state_d = ST_IDLE;
      end
`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
      ST_ESC: begin
        if (accept) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: registered write port, cursor and clear scan position.
  // Colour outputs are loaded on the FF accept too, so the clear pass simply
  // holds them for every space it writes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_en  <= 1'b0;
      h_txt_out <= '0;
      v_txt_out <= '0;
      char_out  <= '0;
      R_fg_out  <= '0;
      G_fg_out  <= '0;
      B_fg_out  <= '0;
      R_bg_out  <= '0;
      G_bg_out  <= '0;
      B_bg_out  <= '0;
      cursor_h  <= '0;
      cursor_v  <= '0;
      clr_h     <= '0;
      clr_v     <= '0;
`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
      pal_fg    <= 3'b111;
      pal_bg    <= 3'b000;
`endif
    end else begin
      write_en <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (char_in)
              CH_LF: begin
                cursor_h <= '0;
                cursor_v <= row_inc;
              end
              CH_CR: cursor_h <= '0;
              CH_BS: begin
                if (cursor_h != '0) cursor_h <= cursor_h - HW'(1);
              end
              CH_FF: begin
                clr_h <= '0;
                clr_v <= '0;
                {R_fg_out, G_fg_out, B_fg_out} <= {sel_R_fg, sel_G_fg, sel_B_fg};
                {R_bg_out, G_bg_out, B_bg_out} <= {sel_R_bg, sel_G_bg, sel_B_bg};
              end
`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
              CH_ESC: begin
              end
`endif
              default: begin
                write_en  <= 1'b1;
                h_txt_out <= cursor_h;
                v_txt_out <= cursor_v;
                char_out  <= char_in;
                {R_fg_out, G_fg_out, B_fg_out} <= {sel_R_fg, sel_G_fg, sel_B_fg};
                {R_bg_out, G_bg_out, B_bg_out} <= {sel_R_bg, sel_G_bg, sel_B_bg};
                cursor_h  <= adv_h;
                cursor_v  <= adv_v;
              end
            endcase
          end
        end
        ST_CLEAR: begin
          write_en  <= 1'b1;
          h_txt_out <= clr_h;
          v_txt_out <= clr_v;
          char_out  <= CH_SPACE;
          if (clear_last) begin
            cursor_h <= '0;
            cursor_v <= '0;
          end else begin
            clr_h <= clr_adv_h;
            clr_v <= clr_adv_v;
          end
        end
`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
        ST_ESC: begin
          if (accept) begin
            pal_fg <= char_in[2:0];
            pal_bg <= char_in[5:3];
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reflet_vga_txt_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reflet_vga_txt_writer
// Purpose  : Self-checking bench for reflet_vga_txt_writer (80x60 default).
//            A cell-level model tracks cursor, pending writes and the clear
//            pass; a compare loop checks the DUT against it every cycle, and
//            a few literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reflet_vga_txt_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int NCELL = COLS * ROWS;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_in    = 8'h00;
  logic [7:0] fr = 8'h00, fgc = 8'h00, fb = 8'h00, br = 8'h00, bgc = 8'h00, bb = 8'h00;

  logic       char_ready;
  logic       write_en;
  logic [6:0] h_txt_out;
  logic [5:0] v_txt_out;
  logic [7:0] char_out;
  logic [7:0] R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out;
  logic [6:0] cursor_h;
  logic [5:0] cursor_v;
  logic       busy;
  logic [47:0] dut_col;

  assign dut_col = {R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out};

  always #5 clk = ~clk;

  reflet_vga_txt_writer dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_in    (char_in),
    .char_ready (char_ready),
    .R_fg_in    (fr),
    .G_fg_in    (fgc),
    .B_fg_in    (fb),
    .R_bg_in    (br),
    .G_bg_in    (bgc),
    .B_bg_in    (bb),
    .write_en   (write_en),
    .h_txt_out  (h_txt_out),
    .v_txt_out  (v_txt_out),
    .char_out   (char_out),
    .R_fg_out   (R_fg_out),
    .G_fg_out   (G_fg_out),
    .B_fg_out   (B_fg_out),
    .R_bg_out   (R_bg_out),
    .G_bg_out   (G_bg_out),
    .B_bg_out   (B_bg_out),
    .cursor_h   (cursor_h),
    .cursor_v   (cursor_v),
    .busy       (busy)
  );

  // --------------------------------------------------------------------------
  // Reference model (cell-level): cursor as integers, clear as a cell index
  // --------------------------------------------------------------------------
  int          m_col = 0, m_row = 0;
  int          m_busy = 0;          // clear cycles still to run
  int          m_idx = 0;           // next linear cell index of the clear
  bit          m_esc = 1'b0;
  logic [2:0]  m_pfg = 3'b111, m_pbg = 3'b000;
  logic [47:0] m_clr_col = '0;
  logic        e_we = 1'b0;
  int          e_h = 0, e_v = 0;
  logic [7:0]  e_ch = 8'h00;
  logic [47:0] e_col = '0;

  function automatic logic [47:0] cur_colours();
`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
    return {{8{m_pfg[0]}}, {8{m_pfg[1]}}, {8{m_pfg[2]}},
            {8{m_pbg[0]}}, {8{m_pbg[1]}}, {8{m_pbg[2]}}};
`else
    return {fr, fgc, fb, br, bgc, bb};
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_col = 0; m_row = 0; m_busy = 0; m_idx = 0; m_esc = 1'b0;
      m_pfg = 3'b111; m_pbg = 3'b000;
      e_we = 1'b0; e_h = 0; e_v = 0; e_ch = 8'h00; e_col = '0;
    end else begin
      e_we = 1'b0;
      if (m_busy > 0) begin
        e_we  = 1'b1;
        e_h   = m_idx % COLS;
        e_v   = m_idx / COLS;
        e_ch  = 8'h20;
        e_col = m_clr_col;
        m_idx++;
        m_busy--;
        if (m_busy == 0) begin m_col = 0; m_row = 0; end
      end else if (char_valid) begin
        if (m_esc) begin
          m_pfg = char_in[2:0];
          m_pbg = char_in[5:3];
          m_esc = 1'b0;
        end else begin
          case (char_in)
            8'h0A: begin m_col = 0; m_row = (m_row + 1) % ROWS; end
            8'h0D: m_col = 0;
            8'h08: if (m_col > 0) m_col--;
            8'h0C: begin m_busy = NCELL; m_idx = 0; m_clr_col = cur_colours(); end
`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
            8'h1B: m_esc = 1'b1;
`endif
            default: begin
              e_we  = 1'b1;
              e_h   = m_col;
              e_v   = m_row;
              e_ch  = char_in;
              e_col = cur_colours();
              if (m_col == COLS - 1) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
              end else begin
                m_col++;
              end
            end
          endcase
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    chk("char_ready", char_ready, reset && (m_busy == 0));
    chk("busy", busy, m_busy != 0);
    chk("write_en", write_en, e_we);
    chk("cursor_h", cursor_h, m_col);
    chk("cursor_v", cursor_v, m_row);
    if (e_we) begin
      chk("h_txt_out", h_txt_out, e_h);
      chk("v_txt_out", v_txt_out, e_v);
      chk("char_out", char_out, e_ch);
      chk("colours", dut_col, e_col);
    end
    if (write_en === 1'b1) we_cnt++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic set_col(input logic [7:0] a, b, c, d, e, f);
    fr = a; fgc = b; fb = c; br = d; bgc = e; bb = f;
  endtask

  // Call just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    char_valid = 1'b1;
    char_in    = b;
    @(negedge clk);
    while (!char_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10000) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: char_ready stayed 0, byte 0x%0h not accepted", b);
    end
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected simulation end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, b0, n;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write_en", write_en, 0);
    chk("rst_char_ready", char_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_char_out", char_out, 0);
    chk("rst_colours", dut_col, 0);
    chk("rst_cursor", {cursor_h, cursor_v}, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // First printable byte
    set_col(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
    send(8'h41);
    chk("A_write_en", write_en, 1);
    chk("A_h", h_txt_out, 0);
    chk("A_v", v_txt_out, 0);
    chk("A_char", char_out, 8'h41);
    chk("A_R_fg", R_fg_out, 8'hFF);
    chk("A_cursor_h", cursor_h, 1);

    // 'A', CR, LF, BS from (0,0)
    pulse_reset();
    w0 = we_cnt;
    send(8'h41); send(8'h0D); send(8'h0A); send(8'h08);
    @(negedge clk); #1;
    chk("seq_writes", we_cnt - w0, 1);
    chk("seq_cursor_h", cursor_h, 0);
    chk("seq_cursor_v", cursor_v, 1);

    // Walk to (79,59) with varying glyphs/colours, then wrap
    @(posedge clk); #1;
    for (int i = 0; i < 58; i++) send(8'h0A);
    for (int i = 0; i < COLS - 1; i++) begin
      set_col(8'(i), 8'(i * 3), 8'(255 - i), 8'(i ^ 8'h5A), 8'(i + 7), 8'(i * 5));
      send(8'h30 + 8'(i % 64));
    end
    set_col(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC);
    send(8'h42);
    chk("wrap_write_en", write_en, 1);
    chk("wrap_h", h_txt_out, 79);
    chk("wrap_v", v_txt_out, 59);
    chk("wrap_char", char_out, 8'h42);
    chk("wrap_cursor", {cursor_h, cursor_v}, 0);

    // Backspace at column 0, CR, LF row wrap
    send(8'h08);
    chk("bs_col0", {cursor_h, cursor_v}, 0);
    send(8'h78); send(8'h79);
    chk("xy_cursor_h", cursor_h, 2);
    send(8'h0D);
    chk("cr_cursor_h", cursor_h, 0);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    chk("lf_row59", cursor_v, 59);
    send(8'h0A);
    chk("lf_wrap", cursor_v, 0);

    // Full clear, with a byte already waiting behind it
    send(8'h71);
    set_col(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    send(8'h0C);
    w0 = we_cnt;
    b0 = busy_cnt;
    set_col(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6);
    send(8'h43);
    @(negedge clk); #1;
    chk("clear_busy_cycles", busy_cnt - b0, NCELL);
    chk("clear_writes", we_cnt - w0, NCELL + 1);
    chk("after_clear_cursor_h", cursor_h, 1);
    chk("after_clear_cursor_v", cursor_v, 0);

    // Reset during a clear
    @(posedge clk); #1;
    send(8'h0C);
    w0 = we_cnt;
    n = 0;
    while ((we_cnt - w0) < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("midclear_reached", (we_cnt - w0) >= 100, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("midclear_write_en", write_en, 0);
    chk("midclear_busy", busy, 0);
    chk("midclear_ready", char_ready, 0);
    chk("midclear_cursor", {cursor_h, cursor_v}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    w0 = we_cnt;
    send(8'h44);
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_writes", we_cnt - w0, 1);

`ifdef REFLET_TXT_WRITER_ESC_COLOR_EN
    // Palette: default white-on-black, then 0x0C palette byte
    pulse_reset();
    set_col(8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55);
    send(8'h50);
    chk("pal_default", dut_col, 48'hFFFFFF_000000);
    w0 = we_cnt;
    send(8'h1B); send(8'h0C); send(8'h5A);
    chk("esc_char", char_out, 8'h5A);
    chk("esc_B_fg", B_fg_out, 8'hFF);
    chk("esc_RG_fg", {R_fg_out, G_fg_out}, 0);
    chk("esc_R_bg", R_bg_out, 8'hFF);
    chk("esc_GB_bg", {G_bg_out, B_bg_out}, 0);
    @(negedge clk); #1;
    chk("esc_writes", we_cnt - w0, 1);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
